vending_ctrl: RTL

//   Sequencing controller for the chocolate vending datapath. Accumulates coin credit in
//   50-bani units and requests a dispense from the dispenser unit via req/ack once credit

---
 rtl/vending_if.sv | 18 +
 rtl/vending_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/vending_if.sv
// Coin/dispense handshake bundle between the vending controller and its environment.
interface vending_if #(parameter int CREDIT_W = 3);
  logic                load50bani;
  logic                load1leu;
  logic                cancel;
  logic                disp_ack;
  logic                disp_req;
  logic                change50;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  // master: coin acceptor / dispenser side; slave: the controller
  modport master (output load50bani, load1leu, cancel, disp_ack,
                  input  disp_req, change50, coin_reject, credit, busy);
  modport slave  (input  load50bani, load1leu, cancel, disp_ack,
                  output disp_req, change50, coin_reject, credit, busy);
endinterface

// File: rtl/vending_ctrl.sv
// Vending sequencer: coin credit accumulation, dispense req/ack, change/refund pulses.
// Optional idle auto-refund enabled by defining REFUND_TIMEOUT_EN.
module vending_ctrl #(
    parameter int PRICE       = 3,
    parameter int MAX_CREDIT  = 7,
    parameter int CREDIT_W    = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic     clk,
    input  logic     rst_n,
    vending_if.slave bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    localparam logic [CREDIT_W:0] PRICE_X = PRICE[CREDIT_W:0];
    localparam logic [CREDIT_W:0] MAX_X   = MAX_CREDIT[CREDIT_W:0];

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                l50_q, l1_q;
    logic                disp_req_q, change_q, change_d, reject_q, reject_d, busy_q;

    logic                ev50, ev1, accept;
    logic [1:0]          coin_val;
    logic [CREDIT_W:0]   sum, base, after_price;

`ifdef REFUND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Coin events are rising edges against one registered sample; simultaneous coins are refused
    always_comb begin
        ev50        = bus.load50bani & ~l50_q;
        ev1         = bus.load1leu & ~l1_q;
        coin_val    = ev1 ? 2'd2 : 2'd1;
        sum         = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
        accept      = (ev50 ^ ev1) && (state_q == IDLE || state_q == COLLECT) && (sum <= MAX_X);
        reject_d    = (ev50 | ev1) & ~accept;
        base        = accept ? sum : {1'b0, credit_q};
        after_price = base - PRICE_X;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = base[CREDIT_W-1:0];
        change_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = COLLECT;
            end
            COLLECT: begin
                if ({1'b0, credit_q} >= PRICE_X) begin
                    state_d  = DISPENSE;
                    credit_d = after_price[CREDIT_W-1:0];
                end else if (bus.cancel) begin
                    state_d = CHANGE;
`ifdef REFUND_TIMEOUT_EN
                end else if (!accept && tmo_q == TMO_LAST) begin
                    state_d = CHANGE;
`endif
                end
            end
            DISPENSE: begin
                if (bus.disp_ack) state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (credit_q != '0) begin
                    change_d = 1'b1;
                    credit_d = credit_q - 1'b1;
                end
                if (credit_q <= CREDIT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef REFUND_TIMEOUT_EN
    // Counts idle cycles spent in COLLECT; cleared on entry and on any accepted coin
    always_comb begin
        tmo_d = '0;
        if (state_q == COLLECT && state_d == COLLECT && !accept) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            l50_q      <= 1'b0;
            l1_q       <= 1'b0;
            disp_req_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            l50_q      <= bus.load50bani;
            l1_q       <= bus.load1leu;
            disp_req_q <= (state_d == DISPENSE);
            change_q   <= change_d;
            reject_q   <= reject_d;
            busy_q     <= (state_d == DISPENSE) || (state_d == CHANGE);
        end
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.change50    = change_q;
    assign bus.coin_reject = reject_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;

endmodule
